lane_queue_sensor_encoder: RTL and testbench
============================================

Name: lane_queue_sensor_encoder

Overview:
- Sensor front-end that produces the S1_*/S5_* inputs of adaptive_traffic_light_controller.
- Consumes raw per-lane vehicle detector pulses: arrival loop upstream, departure loop at the stop line.
- Keeps a saturating queue count per lane and encodes it as S1 (vehicle present) and S5 (long queue, with hysteresis).
- Also reads back the controller's light outputs and flags departures seen on a non-green lane.

Parameters:
- CNT_W, 4: queue counter width; max count = 2^CNT_W-1.
- DEB_CYC, 2: consecutive equal synchronized samples needed to change a debounced detector level (>=1).
- S5_ON, 5: count at or above which S5 asserts.
- S5_OFF, 3: count at or below which S5 deasserts; legal range is S5_OFF < S5_ON <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- arr_raw  in  4  raw arrival detectors, index 0=NS, 1=SN, 2=EW, 3=WE. Asynchronous.
- dep_raw  in  4  raw departure detectors, same indexing. Asynchronous.
- NS_light, SN_light, EW_light, WE_light  in  2 each  light codes from the controller.
- clr_flags  in  1  synchronous clear of the sticky flags.
- S1_NS, S1_SN, S1_EW, S1_WE  out  1 each  lane queue non-empty.
- S5_NS, S5_SN, S5_EW, S5_WE  out  1 each  lane queue long.
- q_count  out  4*CNT_W  packed counts; lane i occupies [i*CNT_W +: CNT_W].
- overflow  out  4  sticky: arrival seen at max count.
- underflow  out  4  sticky: departure seen at count 0.
- violation  out  4  sticky: departure seen while that lane's light is not GREEN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: every flop clears to 0. All S1/S5 = 0, q_count = 0, all flags = 0, synchronizers = 0, debounced levels = 0.
- Synchronizer: 2-flop synchronizer on each of the 8 raw inputs.
- Debounce: per input, a counter of consecutive sync samples that differ from the current debounced level. The level flips on the edge where that counter reaches DEB_CYC; the counter resets whenever a sample equals the level.
- Event: a one-cycle internal event occurs on the edge where the debounced level rises 0->1. Falling edges produce no event.
- Latency: raw input first sampled high at edge t0 and held high -> count updates at edge t0+1+DEB_CYC (t0+3 at default).
- Count update, same edge as the event:
  - Arrival only: +1, saturating at max. An arrival at max holds the count and sets overflow[i].
  - Departure only: -1, saturating at 0. A departure at 0 holds the count and sets underflow[i].
  - Arrival and departure on the same edge: count unchanged, no flag.
- Violation: a departure event while the lane light != GREEN sets violation[i]. The count still decrements.
- S1[i] = (q_count_i != 0). Decoded combinationally from the registered count.
- S5[i]: registered flag updated on the same edge as the count, using the next count value.
  - Set if next >= S5_ON.
  - Clear if next <= S5_OFF.
  - Otherwise hold.
- Sticky flags: cleared only by rst or by clr_flags.
  - clr_flags on the same edge as a new flag event: the set wins.
- Reset mid-operation: counts are lost. A raw input still held high when reset deasserts is treated as a new arrival and counted after the normal latency.
- Lanes are fully independent. No cross-lane arbitration.

Decomposition:
- Shared package traffic_pkg:
  - Light encodings RED=2'b00, YELLOW=2'b01, GREEN=2'b10.
  - Lane indices NS=0, SN=1, EW=2, WE=3.
  - Controller state width constant (4). The controller imports the same package.
- One sub-module, lane_queue_counter, instantiated 4 times. It holds 2 synchronizers, 2 debouncers, the counter, the S5 hysteresis flag and the 3 sticky flags.
- The top level does lane fan-out, light compare and port packing.

Test Plan:
1. Reset then idle 20 cycles -> all S1/S5 = 0, q_count = 0, flags = 0. Assert rst mid-run with NS count 4 -> count 0 immediately (asynchronous).
2. arr_raw[0] pulse held 3 cycles, first sampled at edge t0 -> q_count NS = 1 and S1_NS = 1 at edge t0+3. A 1-cycle glitch (shorter than DEB_CYC) -> no count change.
3. Five clean NS arrivals -> S5_NS rises on the 5th. Departures with NS_light = GREEN: count 4 keeps S5 = 1, count 3 clears S5. Then count 4 again -> S5 stays 0 (hysteresis).
4. EW departure with EW_light = RED at count 2 -> count 1, violation[2] = 1. clr_flags -> violation[2] = 0.
5. WE: 16 arrivals (CNT_W = 4) -> count saturates at 15, overflow[3] = 1. SN departure at count 0 -> count 0, underflow[1] = 1.
6. SN arrival and departure events on the same edge at count 3 -> count stays 3, no flags. Simultaneous arrivals on all 4 lanes -> all counts +1 independently.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings between the sensor front-end and the traffic light controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } light_e;

   localparam int NS = 0;
   localparam int SN = 1;
   localparam int EW = 2;
   localparam int WE = 3;

   localparam int NUM_LANES    = 4;
   localparam int CTRL_STATE_W = 4;

endpackage

// File: rtl/lane_queue_counter.sv
// One lane: synchronize and debounce the arrival/departure loops, keep a
// saturating queue count, a hysteretic long-queue flag and sticky error flags.
module lane_queue_counter #(
   parameter int CNT_W   = 4,
   parameter int DEB_CYC = 2,
   parameter int S5_ON   = 5,
   parameter int S5_OFF  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arr_raw,
   input  logic             dep_raw,
   input  logic             is_green,
   input  logic             clr_flags,
   output logic [CNT_W-1:0] count,
   output logic             s5,
   output logic             overflow,
   output logic             underflow,
   output logic             violation
);

   localparam int DW = $clog2(DEB_CYC + 1);
   localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] MAX_C    = '1;
   localparam logic [CNT_W-1:0] ON_C     = CNT_W'(S5_ON);
   localparam logic [CNT_W-1:0] OFF_C    = CNT_W'(S5_OFF);

   // Bit 0 carries the arrival loop, bit 1 the departure loop.
   logic [1:0]          raw;
   logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]          lvl_q, lvl_d;
   logic [1:0][DW-1:0]  dcnt_q, dcnt_d;
   logic [1:0]          ev;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                s5_q, s5_d;
   logic                ovf_q, ovf_d, unf_q, unf_d, vio_q, vio_d;
   logic                ovf_set, unf_set, vio_set;

   assign raw = {dep_raw, arr_raw};

   // Synchronizer chain and debounce: level flips after DEB_CYC differing samples in a row.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      lvl_d   = lvl_q;
      dcnt_d  = dcnt_q;
      for (int k = 0; k < 2; k++) begin
         if (sync2_q[k] == lvl_q[k]) begin
            dcnt_d[k] = '0;
         end else if (dcnt_q[k] == DEB_LAST) begin
            lvl_d[k]  = ~lvl_q[k];
            dcnt_d[k] = '0;
         end else begin
            dcnt_d[k] = dcnt_q[k] + DW'(1);
         end
      end
   end

   // Rising debounced level is the event; it acts on the same edge the level flips.
   assign ev = lvl_d & ~lvl_q;

   // Queue count, hysteresis flag and sticky flags (a new set beats clr_flags).
   always_comb begin
      cnt_d   = cnt_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (ev[0] && !ev[1]) begin
         if (cnt_q == MAX_C) ovf_set = 1'b1;
         else                cnt_d   = cnt_q + CNT_W'(1);
      end else if (ev[1] && !ev[0]) begin
         if (cnt_q == '0) unf_set = 1'b1;
         else             cnt_d   = cnt_q - CNT_W'(1);
      end
      vio_set = ev[1] & ~is_green;
      s5_d = s5_q;
      if (cnt_d >= ON_C)       s5_d = 1'b1;
      else if (cnt_d <= OFF_C) s5_d = 1'b0;
      ovf_d = (ovf_q & ~clr_flags) | ovf_set;
      unf_d = (unf_q & ~clr_flags) | unf_set;
      vio_d = (vio_q & ~clr_flags) | vio_set;
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         dcnt_q  <= '0;
         cnt_q   <= '0;
         s5_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         vio_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         lvl_q   <= lvl_d;
         dcnt_q  <= dcnt_d;
         cnt_q   <= cnt_d;
         s5_q    <= s5_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         vio_q   <= vio_d;
      end
   end

   assign count     = cnt_q;
   assign s5        = s5_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign violation = vio_q;

endmodule

// File: rtl/lane_queue_sensor_encoder.sv
// Four-lane sensor front-end: fans detectors out to per-lane counters,
// compares each lane's light against GREEN and packs the S1/S5 outputs.
module lane_queue_sensor_encoder
   import traffic_pkg::*;
#(
   parameter int CNT_W   = 4,
   parameter int DEB_CYC = 2,
   parameter int S5_ON   = 5,
   parameter int S5_OFF  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           arr_raw,
   input  logic [3:0]           dep_raw,
   input  logic [1:0]           NS_light,
   input  logic [1:0]           SN_light,
   input  logic [1:0]           EW_light,
   input  logic [1:0]           WE_light,
   input  logic                 clr_flags,
   output logic                 S1_NS,
   output logic                 S1_SN,
   output logic                 S1_EW,
   output logic                 S1_WE,
   output logic                 S5_NS,
   output logic                 S5_SN,
   output logic                 S5_EW,
   output logic                 S5_WE,
   output logic [4*CNT_W-1:0]   q_count,
   output logic [3:0]           overflow,
   output logic [3:0]           underflow,
   output logic [3:0]           violation
);

   logic [3:0][1:0] lights;
   logic [3:0]      s1, s5;

   assign lights[NS] = NS_light;
   assign lights[SN] = SN_light;
   assign lights[EW] = EW_light;
   assign lights[WE] = WE_light;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_queue_counter #(
         .CNT_W   (CNT_W),
         .DEB_CYC (DEB_CYC),
         .S5_ON   (S5_ON),
         .S5_OFF  (S5_OFF)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .arr_raw   (arr_raw[i]),
         .dep_raw   (dep_raw[i]),
         .is_green  (lights[i] == GREEN),
         .clr_flags (clr_flags),
         .count     (q_count[i*CNT_W +: CNT_W]),
         .s5        (s5[i]),
         .overflow  (overflow[i]),
         .underflow (underflow[i]),
         .violation (violation[i])
      );
      assign s1[i] = |q_count[i*CNT_W +: CNT_W];
   end

   assign S1_NS = s1[NS];
   assign S1_SN = s1[SN];
   assign S1_EW = s1[EW];
   assign S1_WE = s1[WE];
   assign S5_NS = s5[NS];
   assign S5_SN = s5[SN];
   assign S5_EW = s5[EW];
   assign S5_WE = s5[WE];

endmodule

// File: tb/tb_lane_queue_sensor_encoder.sv
// Directed bench for lane_queue_sensor_encoder at default parameters.
module tb_lane_queue_sensor_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  arr_raw, dep_raw;
   logic [1:0]  NS_light, SN_light, EW_light, WE_light;
   logic        clr_flags;
   logic        S1_NS, S1_SN, S1_EW, S1_WE;
   logic        S5_NS, S5_SN, S5_EW, S5_WE;
   logic [15:0] q_count;
   logic [3:0]  overflow, underflow, violation;
   logic [3:0]  s1_v, s5_v;

   int checks = 0;
   int errors = 0;

   assign s1_v = {S1_WE, S1_EW, S1_SN, S1_NS};
   assign s5_v = {S5_WE, S5_EW, S5_SN, S5_NS};

   lane_queue_sensor_encoder dut (
      .clk(clk), .rst(rst), .arr_raw(arr_raw), .dep_raw(dep_raw),
      .NS_light(NS_light), .SN_light(SN_light), .EW_light(EW_light), .WE_light(WE_light),
      .clr_flags(clr_flags),
      .S1_NS(S1_NS), .S1_SN(S1_SN), .S1_EW(S1_EW), .S1_WE(S1_WE),
      .S5_NS(S5_NS), .S5_SN(S5_SN), .S5_EW(S5_EW), .S5_WE(S5_WE),
      .q_count(q_count), .overflow(overflow), .underflow(underflow), .violation(violation)
   );

   always #5 clk = ~clk;

   // Hold raw lines high for 3 samples, release, then idle until the debounced level has fallen.
   task automatic send(input logic [3:0] a, input logic [3:0] d);
      arr_raw = a;
      dep_raw = d;
      repeat (3) @(negedge clk);
      arr_raw = '0;
      dep_raw = '0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (20) @(negedge clk);
      checks++; if (q_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0000", q_count); end
      checks++; if (s1_v !== 4'h0) begin errors++; $display("FAIL reset_s1 got %b want 0000", s1_v); end
      checks++; if (s5_v !== 4'h0) begin errors++; $display("FAIL reset_s5 got %b want 0000", s5_v); end
      checks++; if ({overflow, underflow, violation} !== 12'h0) begin errors++;
         $display("FAIL reset_flags got %h want 000", {overflow, underflow, violation}); end
   endtask

   task automatic test_latency();
      // Driven before edge t0; still 0 after t0+2, 1 after t0+3.
      arr_raw = 4'b0001;
      repeat (3) @(negedge clk);
      arr_raw = '0;
      checks++; if (q_count[3:0] !== 4'd0) begin errors++; $display("FAIL latency_early got %0d want 0", q_count[3:0]); end
      @(negedge clk);
      checks++; if (q_count[3:0] !== 4'd1) begin errors++; $display("FAIL latency_count got %0d want 1", q_count[3:0]); end
      checks++; if (S1_NS !== 1'b1) begin errors++; $display("FAIL latency_s1 got %b want 1", S1_NS); end
      repeat (4) @(negedge clk);
      // One-sample glitch is filtered.
      arr_raw = 4'b0001;
      @(negedge clk);
      arr_raw = '0;
      repeat (8) @(negedge clk);
      checks++; if (q_count[3:0] !== 4'd1) begin errors++; $display("FAIL glitch_count got %0d want 1", q_count[3:0]); end
   endtask

   task automatic test_hysteresis();
      logic [3:0] exp_s5 [0:3];
      exp_s5 = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         send(4'b0001, 4'b0000);
         checks++; if (q_count[3:0] !== 4'(k + 2) || S5_NS !== exp_s5[k][0]) begin errors++;
            $display("FAIL hyst_up count %0d s5 %b want %0d %b", q_count[3:0], S5_NS, k + 2, exp_s5[k][0]); end
      end
      send(4'b0000, 4'b0001);
      checks++; if (q_count[3:0] !== 4'd4 || S5_NS !== 1'b1) begin errors++;
         $display("FAIL hyst_hold4 count %0d s5 %b want 4 1", q_count[3:0], S5_NS); end
      send(4'b0000, 4'b0001);
      checks++; if (q_count[3:0] !== 4'd3 || S5_NS !== 1'b0) begin errors++;
         $display("FAIL hyst_off3 count %0d s5 %b want 3 0", q_count[3:0], S5_NS); end
      send(4'b0001, 4'b0000);
      checks++; if (q_count[3:0] !== 4'd4 || S5_NS !== 1'b0) begin errors++;
         $display("FAIL hyst_stay0 count %0d s5 %b want 4 0", q_count[3:0], S5_NS); end
      checks++; if (violation !== 4'b0000) begin errors++; $display("FAIL hyst_green_vio got %b want 0000", violation); end
   endtask

   task automatic test_async_reset();
      #2 rst = 1'b1;
      #1;
      checks++; if (q_count !== 16'h0 || s1_v !== 4'h0) begin errors++;
         $display("FAIL async_reset count %h s1 %b want 0000 0000", q_count, s1_v); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_violation();
      EW_light = 2'b00;
      send(4'b0100, 4'b0000);
      send(4'b0100, 4'b0000);
      send(4'b0000, 4'b0100);
      checks++; if (q_count[11:8] !== 4'd1) begin errors++; $display("FAIL vio_count got %0d want 1", q_count[11:8]); end
      checks++; if (violation !== 4'b0100) begin errors++; $display("FAIL vio_set got %b want 0100", violation); end
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      checks++; if (violation !== 4'b0000 || q_count[11:8] !== 4'd1) begin errors++;
         $display("FAIL vio_clear vio %b count %0d want 0000 1", violation, q_count[11:8]); end
      EW_light = 2'b10;
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 15; k++) send(4'b1000, 4'b0000);
      checks++; if (q_count[15:12] !== 4'd15 || overflow !== 4'b0000) begin errors++;
         $display("FAIL sat_15 count %0d ovf %b want 15 0000", q_count[15:12], overflow); end
      send(4'b1000, 4'b0000);
      checks++; if (q_count[15:12] !== 4'd15 || overflow !== 4'b1000 || S5_WE !== 1'b1) begin errors++;
         $display("FAIL sat_ovf count %0d ovf %b s5 %b want 15 1000 1", q_count[15:12], overflow, S5_WE); end
      send(4'b0000, 4'b0010);
      checks++; if (q_count[7:4] !== 4'd0 || underflow !== 4'b0010) begin errors++;
         $display("FAIL sat_unf count %0d unf %b want 0 0010", q_count[7:4], underflow); end
   endtask

   task automatic test_simultaneous();
      test_async_reset();
      for (int k = 0; k < 3; k++) send(4'b0010, 4'b0000);
      send(4'b0010, 4'b0010);
      checks++; if (q_count[7:4] !== 4'd3 || {overflow, underflow, violation} !== 12'h0) begin errors++;
         $display("FAIL same_edge count %0d flags %h want 3 000", q_count[7:4], {overflow, underflow, violation}); end
      send(4'b1111, 4'b0000);
      checks++; if (q_count !== 16'h1141) begin errors++; $display("FAIL all_lanes got %h want 1141", q_count); end
      checks++; if (s1_v !== 4'b1111) begin errors++; $display("FAIL all_lanes_s1 got %b want 1111", s1_v); end
   endtask

   initial begin
      rst = 1'b1;
      arr_raw = '0;
      dep_raw = '0;
      clr_flags = 1'b0;
      NS_light = 2'b10;
      SN_light = 2'b10;
      EW_light = 2'b10;
      WE_light = 2'b10;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_latency();
      test_hysteresis();
      test_async_reset();
      test_violation();
      test_saturation();
      test_simultaneous();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
